std_dcache_bank_arbiter: RTL and testbench

//   Parametrised successor to the fixed 4-port tag_cmp arbitration of the

---
 rtl/std_dcache_bank_arbiter.sv | 177 +++++++++++++++++
 tb/tb_std_dcache_bank_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_dcache_bank_arbiter.sv
// Arbitrates NR_PORTS dcache requesters onto one shared set of SET_ASSOC banks.
// It registers the read winner and produces rvalid/hit_way/multi_hit one cycle later.
// Optional anti-starvation counter for port 0 priority: STD_DCACHE_ARB_FAIRNESS_EN.
module std_dcache_bank_arbiter #(
  parameter int unsigned NR_PORTS   = 4,
  parameter int unsigned SET_ASSOC  = 8,
  parameter int unsigned IDX_W      = 12,
  parameter int unsigned TAG_W      = 44,
  parameter int unsigned LINE_W     = 128
`ifdef STD_DCACHE_ARB_FAIRNESS_EN
  ,
  parameter int unsigned MAX_STARVE = 8
`endif
) (
  input  logic                                               clk_i,
  input  logic                                               rst_i,
  input  logic [NR_PORTS*SET_ASSOC-1:0]                      req_i,
  input  logic [NR_PORTS*IDX_W-1:0]                          addr_i,
  input  logic [NR_PORTS*TAG_W-1:0]                          tag_i,
  input  logic [NR_PORTS-1:0]                                we_i,
  input  logic [NR_PORTS*(TAG_W+LINE_W+2)-1:0]               wdata_i,
  input  logic [NR_PORTS*(TAG_W/8+LINE_W/8+SET_ASSOC)-1:0]   be_i,
  output logic [NR_PORTS-1:0]                                gnt_o,
  output logic [NR_PORTS-1:0]                                rvalid_o,
  output logic [SET_ASSOC*(TAG_W+LINE_W+2)-1:0]              rdata_o,
  output logic [SET_ASSOC-1:0]                               hit_way_o,
  output logic                                               multi_hit_o,
  output logic [SET_ASSOC-1:0]                               bank_req_o,
  output logic [IDX_W-1:0]                                   bank_addr_o,
  output logic                                               bank_we_o,
  output logic [TAG_W+LINE_W+1:0]                            bank_wdata_o,
  output logic [TAG_W/8+LINE_W/8+SET_ASSOC-1:0]              bank_be_o,
  input  logic [SET_ASSOC*(TAG_W+LINE_W+2)-1:0]              bank_rdata_i
);

  localparam int unsigned DATA_W = TAG_W + LINE_W + 2;
  localparam int unsigned BE_W   = TAG_W/8 + LINE_W/8 + SET_ASSOC;
  localparam int unsigned PTR_W  = $clog2(NR_PORTS);

  logic [NR_PORTS-1:0]  w_req;
  logic [NR_PORTS-1:0]  w_gnt;
  logic [PTR_W-1:0]     w_rr_win;
  logic                 w_rr_any;
  logic                 w_force_rr;
  logic [PTR_W-1:0]     w_win_idx;
  logic [TAG_W-1:0]     w_win_tag;
  logic [SET_ASSOC-1:0] w_hit;

  logic [PTR_W-1:0]     r_rr_ptr;
  logic                 r_valid_s;
  logic [PTR_W-1:0]     r_port_s;
  logic [TAG_W-1:0]     r_tag_s;

  always_comb begin : req_reduce
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      w_req[p] = |req_i[p*SET_ASSOC +: SET_ASSOC];
    end
  end

  // Round-robin search over ports 1..N-1: first requester at/above rr_ptr, else lowest below it.
  always_comb begin : rr_search
    logic [PTR_W-1:0] v_hi;
    logic [PTR_W-1:0] v_lo;
    logic             v_hi_ok;
    logic             v_lo_ok;
    v_hi    = '0;
    v_lo    = '0;
    v_hi_ok = 1'b0;
    v_lo_ok = 1'b0;
    for (int p = int'(NR_PORTS) - 1; p >= 1; p--) begin
      if (w_req[p]) begin
        if (PTR_W'(p) >= r_rr_ptr) begin
          v_hi    = PTR_W'(p);
          v_hi_ok = 1'b1;
        end else begin
          v_lo    = PTR_W'(p);
          v_lo_ok = 1'b1;
        end
      end
    end
    w_rr_any = v_hi_ok | v_lo_ok;
    w_rr_win = v_hi_ok ? v_hi : v_lo;
  end

  always_comb begin : grant
    w_gnt = '0;
    if (!rst_i) begin
      if (w_req[0] && !(w_force_rr && w_rr_any)) begin
        w_gnt[0] = 1'b1;
      end else if (w_rr_any) begin
        for (int p = 1; p < int'(NR_PORTS); p++) begin
          w_gnt[p] = (PTR_W'(p) == w_rr_win);
        end
      end
    end
  end

  assign gnt_o   = w_gnt;
  assign rdata_o = bank_rdata_i;

  // One-hot grant steers the winner's request fields onto the bank interface.
  always_comb begin : bank_mux
    bank_req_o   = '0;
    bank_addr_o  = '0;
    bank_we_o    = 1'b0;
    bank_wdata_o = '0;
    bank_be_o    = '0;
    w_win_idx    = '0;
    w_win_tag    = '0;
    for (int p = 0; p < int'(NR_PORTS); p++) begin
      if (w_gnt[p]) begin
        bank_req_o   = req_i[p*SET_ASSOC +: SET_ASSOC];
        bank_addr_o  = addr_i[p*IDX_W +: IDX_W];
        bank_we_o    = we_i[p];
        bank_wdata_o = wdata_i[p*DATA_W +: DATA_W];
        bank_be_o    = be_i[p*BE_W +: BE_W];
        w_win_idx    = PTR_W'(p);
        w_win_tag    = tag_i[p*TAG_W +: TAG_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin : stage_reg
    if (rst_i) begin
      r_rr_ptr  <= PTR_W'(1);
      r_valid_s <= 1'b0;
      r_port_s  <= '0;
      r_tag_s   <= '0;
    end else begin
      r_valid_s <= (|w_gnt) & ~bank_we_o;
      r_port_s  <= w_win_idx;
      r_tag_s   <= w_win_tag;
      if (|w_gnt[NR_PORTS-1:1]) begin
        r_rr_ptr <= (w_win_idx == PTR_W'(NR_PORTS - 1)) ? PTR_W'(1) : w_win_idx + PTR_W'(1);
      end
    end
  end

`ifdef STD_DCACHE_ARB_FAIRNESS_EN
  localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);

  logic [STARVE_W-1:0] r_starve_cnt;

  assign w_force_rr = (r_starve_cnt == STARVE_W'(MAX_STARVE));

  // Counts port-0 wins that left a controller waiting; cleared when a controller wins.
  always_ff @(posedge clk_i) begin : starve_counter
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (|w_gnt[NR_PORTS-1:1]) begin
      r_starve_cnt <= '0;
    end else if (w_gnt[0] && w_rr_any) begin
      r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
    end
  end
`else
  assign w_force_rr = 1'b0;
`endif

  // Tag compare against the 1-cycle SRAM read; everything is squashed while in reset.
  always_comb begin : response
    w_hit = '0;
    for (int i = 0; i < int'(SET_ASSOC); i++) begin
      w_hit[i] = r_valid_s & bank_rdata_i[i*DATA_W + DATA_W - 1]
               & (bank_rdata_i[i*DATA_W + LINE_W +: TAG_W] == r_tag_s);
    end
    rvalid_o = '0;
    if (r_valid_s && !rst_i) begin
      for (int p = 0; p < int'(NR_PORTS); p++) begin
        rvalid_o[p] = (PTR_W'(p) == r_port_s);
      end
    end
    hit_way_o   = rst_i ? '0 : w_hit;
    multi_hit_o = !rst_i && r_valid_s && ((w_hit & (w_hit - SET_ASSOC'(1))) != '0);
  end

endmodule

// File: tb/tb_std_dcache_bank_arbiter.sv
// Scoreboard bench for std_dcache_bank_arbiter (default parameters).
module tb_std_dcache_bank_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned SA = 8;
  localparam int unsigned IW = 12;
  localparam int unsigned TW = 44;
  localparam int unsigned LW = 128;
  localparam int unsigned DW = TW + LW + 2;
  localparam int unsigned BW = TW/8 + LW/8 + SA;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [NP*SA-1:0] req_i;
  logic [NP*IW-1:0] addr_i;
  logic [NP*TW-1:0] tag_i;
  logic [NP-1:0]    we_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP*BW-1:0] be_i;
  logic [NP-1:0]    gnt_o;
  logic [NP-1:0]    rvalid_o;
  logic [SA*DW-1:0] rdata_o;
  logic [SA-1:0]    hit_way_o;
  logic             multi_hit_o;
  logic [SA-1:0]    bank_req_o;
  logic [IW-1:0]    bank_addr_o;
  logic             bank_we_o;
  logic [DW-1:0]    bank_wdata_o;
  logic [BW-1:0]    bank_be_o;
  logic [SA*DW-1:0] bank_rdata_i;

  typedef struct packed {
    logic [NP-1:0] rvalid;
    logic [SA-1:0] hit;
    logic          multi;
  } rsp_t;

  rsp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  std_dcache_bank_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .addr_i(addr_i), .tag_i(tag_i),
    .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .hit_way_o(hit_way_o), .multi_hit_o(multi_hit_o),
    .bank_req_o(bank_req_o), .bank_addr_o(bank_addr_o), .bank_we_o(bank_we_o),
    .bank_wdata_o(bank_wdata_o), .bank_be_o(bank_be_o), .bank_rdata_i(bank_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic clear_ports();
    req_i = '0; addr_i = '0; tag_i = '0; we_i = '0; wdata_i = '0; be_i = '0;
  endtask

  task automatic drive_port(input int p, input logic we, input logic [IW-1:0] a,
                            input logic [TW-1:0] t);
    req_i[p*SA +: SA]   = '1;
    addr_i[p*IW +: IW]  = a;
    tag_i[p*TW +: TW]   = t;
    we_i[p]             = we;
    wdata_i[p*DW +: DW] = {1'b1, 1'b0, t, LW'(p)};
    be_i[p*BW +: BW]    = '1;
  endtask

  task automatic set_way(input int w, input logic v, input logic [TW-1:0] t);
    bank_rdata_i[w*DW +: DW] = {v, 1'b0, t, {LW{1'b0}}};
  endtask

  task automatic test_reset();
    rsp_t got;
    rst_i = 1'b1;
    clear_ports();
    drive_port(0, 1'b0, 12'h010, 44'h1);
    drive_port(2, 1'b1, 12'h020, 44'h2);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_total++; if (gnt_o !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt_o); else n_pass++;
    n_total++; if (bank_req_o !== 8'h00) $display("FAIL reset_bank_req got %h exp 00", bank_req_o); else n_pass++;
    n_total++; if (bank_we_o !== 1'b0) $display("FAIL reset_bank_we got %b exp 0", bank_we_o); else n_pass++;
    got = {rvalid_o, hit_way_o, multi_hit_o};
    n_total++; if (got !== rsp_t'(0)) $display("FAIL reset_rsp got %h exp 0", got); else n_pass++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_ports();
    @(negedge clk_i);
    n_total++; if (gnt_o !== 4'b0000) $display("FAIL post_reset_gnt got %b exp 0000", gnt_o); else n_pass++;
    n_total++; if (rvalid_o !== 4'b0000) $display("FAIL post_reset_rvalid got %b exp 0000", rvalid_o); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] exp_g [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010,
                                 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    rsp_t e, got;
    for (int w = 0; w < int'(SA); w++) set_way(w, 1'b0, 44'h0);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk_i); #1;
      clear_ports();
      if (i < 8) begin
        for (int p = 1; p < int'(NP); p++) drive_port(p, 1'b0, 12'(i), 44'(p));
        if (i == 6) drive_port(0, 1'b0, 12'h0FF, 44'h7);
      end
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {rvalid_o, hit_way_o, multi_hit_o};
        n_total++; if (got !== e) $display("FAIL rr_rsp[%0d] got %h exp %h", i, got, e); else n_pass++;
      end
      if (i < 8) begin
        n_total++; if (gnt_o !== exp_g[i]) $display("FAIL rr_gnt[%0d] got %b exp %b", i, gnt_o, exp_g[i]); else n_pass++;
        sb.push_back({exp_g[i], 8'h00, 1'b0});
      end
    end
  endtask

  task automatic test_single_read();
    rsp_t e, got;
    for (int w = 0; w < int'(SA); w++) set_way(w, 1'b0, 44'h0);
    set_way(3, 1'b1, 44'hABC);
    set_way(1, 1'b1, 44'hABD);
    set_way(6, 1'b0, 44'hABC);
    @(posedge clk_i); #1;
    clear_ports();
    drive_port(2, 1'b0, 12'h040, 44'hABC);
    @(negedge clk_i);
    n_total++; if (gnt_o !== 4'b0100) $display("FAIL read_gnt got %b exp 0100", gnt_o); else n_pass++;
    n_total++; if (bank_addr_o !== 12'h040) $display("FAIL read_addr got %h exp 040", bank_addr_o); else n_pass++;
    n_total++; if (bank_req_o !== 8'hFF) $display("FAIL read_bank_req got %h exp ff", bank_req_o); else n_pass++;
    n_total++; if (bank_we_o !== 1'b0) $display("FAIL read_bank_we got %b exp 0", bank_we_o); else n_pass++;
    sb.push_back({4'b0100, 8'h08, 1'b0});
    @(posedge clk_i); #1;
    clear_ports();
    @(negedge clk_i);
    e = sb.pop_front();
    got = {rvalid_o, hit_way_o, multi_hit_o};
    n_total++; if (got !== e) $display("FAIL read_rsp got %h exp %h", got, e); else n_pass++;
    n_total++; if (bank_req_o !== 8'h00) $display("FAIL idle_bank_req got %h exp 00", bank_req_o); else n_pass++;
    n_total++; if (rdata_o !== bank_rdata_i) $display("FAIL rdata_pass got %h exp %h", rdata_o, bank_rdata_i); else n_pass++;
  endtask

  task automatic test_write();
    rsp_t e, got;
    logic [DW-1:0] exp_wd;
    exp_wd = {1'b1, 1'b0, 44'h55, 128'd1};
    for (int w = 0; w < int'(SA); w++) set_way(w, 1'b0, 44'h0);
    set_way(0, 1'b1, 44'h55);
    @(posedge clk_i); #1;
    clear_ports();
    drive_port(1, 1'b1, 12'h123, 44'h55);
    @(negedge clk_i);
    n_total++; if (gnt_o !== 4'b0010) $display("FAIL write_gnt got %b exp 0010", gnt_o); else n_pass++;
    n_total++; if (bank_we_o !== 1'b1) $display("FAIL write_bank_we got %b exp 1", bank_we_o); else n_pass++;
    n_total++; if (bank_addr_o !== 12'h123) $display("FAIL write_addr got %h exp 123", bank_addr_o); else n_pass++;
    n_total++; if (bank_wdata_o !== exp_wd) $display("FAIL write_wdata got %h exp %h", bank_wdata_o, exp_wd); else n_pass++;
    sb.push_back({4'b0000, 8'h00, 1'b0});
    @(posedge clk_i); #1;
    clear_ports();
    @(negedge clk_i);
    e = sb.pop_front();
    got = {rvalid_o, hit_way_o, multi_hit_o};
    n_total++; if (got !== e) $display("FAIL write_rsp got %h exp %h", got, e); else n_pass++;
    n_total++; if (bank_we_o !== 1'b0) $display("FAIL write_idle_we got %b exp 0", bank_we_o); else n_pass++;
  endtask

  task automatic test_multi_hit();
    rsp_t e, got;
    for (int w = 0; w < int'(SA); w++) set_way(w, 1'b0, 44'h0);
    set_way(0, 1'b1, 44'h12);
    set_way(5, 1'b1, 44'h12);
    set_way(2, 1'b1, 44'h13);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      clear_ports();
      if (i == 0) drive_port(3, 1'b0, 12'h200, 44'h12);
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        got = {rvalid_o, hit_way_o, multi_hit_o};
        n_total++; if (got !== e) $display("FAIL multi_rsp[%0d] got %h exp %h", i, got, e); else n_pass++;
      end
      if (i == 0) begin
        n_total++; if (gnt_o !== 4'b1000) $display("FAIL multi_gnt got %b exp 1000", gnt_o); else n_pass++;
        sb.push_back({4'b1000, 8'h21, 1'b1});
      end else if (i == 1) begin
        sb.push_back({4'b0000, 8'h00, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    rsp_t e, got;
    for (int w = 0; w < int'(SA); w++) set_way(w, 1'b0, 44'h0);
    set_way(3, 1'b1, 44'hABC);
    @(posedge clk_i); #1;
    clear_ports();
    drive_port(2, 1'b0, 12'h040, 44'hABC);
    @(negedge clk_i);
    n_total++; if (gnt_o !== 4'b0100) $display("FAIL rmf_gnt got %b exp 0100", gnt_o); else n_pass++;
    sb.push_back({4'b0000, 8'h00, 1'b0});
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    clear_ports();
    drive_port(1, 1'b0, 12'h041, 44'hABC);
    @(negedge clk_i);
    e = sb.pop_front();
    got = {rvalid_o, hit_way_o, multi_hit_o};
    n_total++; if (got !== e) $display("FAIL rmf_dropped got %h exp %h", got, e); else n_pass++;
    n_total++; if (gnt_o !== 4'b0000) $display("FAIL rmf_gnt_in_reset got %b exp 0000", gnt_o); else n_pass++;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_ports();
    drive_port(1, 1'b0, 12'h050, 44'h0);
    drive_port(3, 1'b0, 12'h060, 44'h0);
    @(negedge clk_i);
    n_total++; if (gnt_o !== 4'b0010) $display("FAIL rmf_gnt_after got %b exp 0010", gnt_o); else n_pass++;
    n_total++; if (rvalid_o !== 4'b0000) $display("FAIL rmf_rvalid_after got %b exp 0000", rvalid_o); else n_pass++;
    sb.push_back({4'b0010, 8'h00, 1'b0});
    @(posedge clk_i); #1;
    clear_ports();
    @(negedge clk_i);
    e = sb.pop_front();
    got = {rvalid_o, hit_way_o, multi_hit_o};
    n_total++; if (got !== e) $display("FAIL rmf_rsp_after got %h exp %h", got, e); else n_pass++;
  endtask

  task automatic test_fairness();
    logic [NP-1:0] exp_g;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i); #1;
      clear_ports();
      drive_port(0, 1'b1, 12'h300, 44'h0);
      drive_port(1, 1'b1, 12'h301, 44'h0);
`ifdef STD_DCACHE_ARB_FAIRNESS_EN
      exp_g = ((i % 9) == 8) ? 4'b0010 : 4'b0001;
`else
      exp_g = 4'b0001;
`endif
      @(negedge clk_i);
      n_total++; if (gnt_o !== exp_g) $display("FAIL fair_gnt[%0d] got %b exp %b", i, gnt_o, exp_g); else n_pass++;
    end
    @(posedge clk_i); #1;
    clear_ports();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ports();
    bank_rdata_i = '0;
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_multi_hit();
    test_reset_mid_flight();
    test_fairness();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
